// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the bypassing register file.
package regfile_pkg;

  localparam int unsigned DEF_WIDTH = 32'd64;
  localparam int unsigned DEF_DEPTH = 32'd32;
  localparam int unsigned DEF_NREAD = 32'd2;
  localparam int unsigned DEF_AW    = $clog2(DEF_DEPTH);

  typedef logic [DEF_NREAD-1:0][DEF_AW-1:0] rd_addr_arr_t;

  // The hardwired-zero register is the top index (X31/XZR in the default build).
  function automatic int unsigned zero_idx(input int unsigned depth);
    return depth - 32'd1;
  endfunction

endpackage

// File: rtl/regfile_slot.sv
// One architectural register plus its pending-write (busy) bit.
module regfile_slot #(
  parameter int unsigned WIDTH = 32'd64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_wr,
  input  logic             i_claim,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_value,
  output logic             o_busy
);

  logic [WIDTH-1:0] r_value;
  logic             r_busy;

  // Data storage: a flush never discards a write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_value <= '0;
    end else if (i_wr) begin
      r_value <= i_data;
    end
  end

  // Busy tracking: flush beats claim, and a new claim beats a retiring write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= 1'b0;
    end else if (i_flush) begin
      r_busy <= 1'b0;
    end else if (i_claim) begin
      r_busy <= 1'b1;
    end else if (i_wr) begin
      r_busy <= 1'b0;
    end
  end

  assign o_value = r_value;
  assign o_busy  = r_busy;

endmodule

// File: rtl/regfile_bypass.sv
// Parametrised register file with write-to-read bypass, zero register and busy scoreboard.
module regfile_bypass
  import regfile_pkg::*;
#(
  parameter  int unsigned WIDTH    = DEF_WIDTH,
  parameter  int unsigned DEPTH    = DEF_DEPTH,
  parameter  int unsigned NREAD    = DEF_NREAD,
  parameter  bit          ZERO_REG = 1'b1,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*WIDTH-1:0] rd_data,
  output logic [NREAD-1:0]       rd_busy,
  input  logic                   claim_en,
  input  logic [AW-1:0]          claim_addr,
  input  logic                   flush
);

  localparam int unsigned ZIDX = zero_idx(DEPTH);

  logic [DEPTH-1:0] w_wr_sel;
  logic [DEPTH-1:0] w_claim_sel;
  logic [WIDTH-1:0] w_val [DEPTH];
  logic [DEPTH-1:0] w_busy;

  // One-hot write and claim decode.
  always_comb begin
    w_wr_sel    = '0;
    w_claim_sel = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_wr_sel[i]    = wr_en && (wr_addr == AW'(i));
      w_claim_sel[i] = claim_en && (claim_addr == AW'(i));
    end
  end

  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_slot
    if (ZERO_REG && (g == int'(ZIDX))) begin : g_zero
      // Writes and claims aimed at the zero register simply fall away.
      logic w_unused_zero;
      assign w_unused_zero = w_wr_sel[g] | w_claim_sel[g];
      assign w_val[g]      = '0;
      assign w_busy[g]     = 1'b0;
    end else begin : g_reg
      regfile_slot #(.WIDTH(WIDTH)) u_slot (
        .clk     (clk),
        .reset_n (reset_n),
        .i_wr    (w_wr_sel[g]),
        .i_claim (w_claim_sel[g]),
        .i_flush (flush),
        .i_data  (wr_data),
        .o_value (w_val[g]),
        .o_busy  (w_busy[g])
      );
    end
  end

  for (genvar p = 0; p < int'(NREAD); p++) begin : g_rd
    logic [AW-1:0]    w_ra;
    logic [WIDTH-1:0] w_rd_data;
    logic             w_rd_busy;

    assign w_ra = rd_addr[p*AW +: AW];

    // Read mux: zero override, then same-cycle bypass, then the array.
    always_comb begin
      w_rd_data = '0;
      w_rd_busy = 1'b0;
      if (ZERO_REG && (w_ra == AW'(ZIDX))) begin
        w_rd_data = '0;
        w_rd_busy = 1'b0;
      end else if (wr_en && (wr_addr == w_ra)) begin
        w_rd_data = wr_data;
        w_rd_busy = 1'b0;
      end else begin
        w_rd_data = w_val[w_ra];
        w_rd_busy = w_busy[w_ra];
      end
    end

    assign rd_data[p*WIDTH +: WIDTH] = w_rd_data;
    assign rd_busy[p]                = w_rd_busy;
  end

endmodule
